// File: rtl/rca4_bist.sv
// Built-in self-test engine for the 4-bit ripple-carry add/subtract unit.
// Sweeps all 1024 {op,cin,a,b} vectors, checks them against a golden model and logs the first failure.
module rca4_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] err_cnt,
  output logic        fail_valid,
  output logic [9:0]  fail_vec,
  output logic [3:0]  fail_sum,
  output logic        fail_cout,
  output logic [3:0]  a,
  output logic [3:0]  b,
  output logic        cin,
  output logic        op,
  input  logic [3:0]  sum,
  input  logic        cout
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [9:0]  vec_q, vec_d;
  logic [3:0]  settle_q, settle_d;
  logic [10:0] err_cnt_q, err_cnt_d;
  logic        fail_valid_q, fail_valid_d;
  logic [9:0]  fail_vec_q, fail_vec_d;
  logic [3:0]  fail_sum_q, fail_sum_d;
  logic        fail_cout_q, fail_cout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mismatch;

  // Subtract forms a + ~b + 1 and ignores cin; cout=1 means no borrow.
  function automatic logic [4:0] golden(input logic [9:0] v);
    logic [3:0] nb;
    logic [4:0] r;
    nb = ~v[3:0];
    if (v[9]) r = {1'b0, v[7:4]} + {1'b0, nb} + 5'd1;
    else      r = {1'b0, v[7:4]} + {1'b0, v[3:0]} + {4'b0, v[8]};
    return r;
  endfunction

  assign mismatch = ({cout, sum} != golden(vec_q));

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_d     = settle_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_sum_d   = fail_sum_q;
    fail_cout_d  = fail_cout_q;
    busy_d       = busy_q;
    done_d       = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_APPLY;
          vec_d        = '0;
          settle_d     = '0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          fail_sum_d   = '0;
          fail_cout_d  = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
        end
      end
      S_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = S_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_cnt_d = err_cnt_q + 11'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
            fail_sum_d   = sum;
            fail_cout_d  = cout;
          end
        end
        if (vec_q == 10'h3FF) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          vec_d   = vec_q + 10'd1;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_sum_q   <= '0;
      fail_cout_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_q     <= settle_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_sum_q   <= fail_sum_d;
      fail_cout_q  <= fail_cout_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign op         = vec_q[9];
  assign cin        = vec_q[8];
  assign a          = vec_q[7:4];
  assign b          = vec_q[3:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_cnt_q == 11'd0);
  assign err_cnt    = err_cnt_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_sum   = fail_sum_q;
  assign fail_cout  = fail_cout_q;

endmodule
